sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Two-requester Avalon-MM arbiter that shares the single SDRAM controller port of the Nios system between the Nios data master (requester 0) and the hardware acceleration engine (requester 1). It grants one single-beat read or write at a time to the SDRAM master port. It tracks outstanding pipelined reads in a tag FIFO so each `readdatavalid` beat is routed back to the requester that issued the read. It sits between both requesters and the SDRAM controller slave, clocked from the 50 MHz system clock.

## Interface
Parameters:
- `ADDR_W`, 25: word address width (32M x 16-bit SDRAM)
- `DATA_W`, 16: data width; byte-enable width `BE_W = DATA_W/8`
- `MAX_PEND`, 4: maximum outstanding reads (tag FIFO depth, power of two)

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk_50` in 1: system clock
- `reset_n` in 1: asynchronous active-low reset
- `s0_address`/`s1_address` in ADDR_W: requester word address
- `s0_read`, `s0_write`/`s1_read`, `s1_write` in 1: command strobes
- `s0_writedata`/`s1_writedata` in DATA_W; `s0_byteenable`/`s1_byteenable` in BE_W
- `s0_waitrequest`/`s1_waitrequest` out 1: command not yet accepted
- `s0_readdata`/`s1_readdata` out DATA_W; `s0_readdatavalid`/`s1_readdatavalid` out 1
- `m_address` out ADDR_W; `m_read`, `m_write` out 1; `m_writedata` out DATA_W; `m_byteenable` out BE_W
- `m_waitrequest` in 1; `m_readdata` in DATA_W; `m_readdatavalid` in 1
- `err` out 1: sticky, `readdatavalid` received with no read outstanding

## Operation
- FSM states:
  - ARB: registers the winner into `grant`, then moves to BUSY.
    - Requests are `sN_read|sN_write`.
    - Reads are eligible only if the tag FIFO is not full; writes are always eligible.
    - With no eligible request, stays in ARB.
  - BUSY: drives `m_*` from the granted requester's live signals.
    - On `m_waitrequest==0` with `m_read|m_write`, the command is accepted: `s<grant>_waitrequest` is low for that cycle, a read pushes `grant` into the tag FIFO, and the FSM returns to ARB.
    - If the granted requester drops its request, returns to ARB with no command issued.
- `sN_waitrequest = !(state==BUSY && grant==N && !m_waitrequest)`. The ungranted requester is held off.
- Read return:
  - `m_readdatavalid` pops the FIFO head tag T.
  - Next cycle: `sT_readdatavalid=1`, `sT_readdata` = registered `m_readdata`.
  - The other requester's `readdatavalid` stays 0.
  - Read data returns strictly in order.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Pop with an empty FIFO: the beat is dropped, `err` is set, and `err` clears only on reset.
- Avalon rule: requesters hold address, data and strobes stable while waitrequest is high.

## Timing
- Reset values:
  - state ARB; `grant=0`; round-robin pointer 0; FIFO empty.
  - `m_read=m_write=0`, `m_address`/`m_writedata`/`m_byteenable` = 0.
  - `s0_waitrequest=s1_waitrequest=1`; both `readdatavalid=0`; readdata 0; `err=0`.
- Command latency: request asserted in cycle N; `m_read`/`m_write` asserted in N+1. Accepted no earlier than N+1.
- Throughput: at most one command every 2 cycles (the ARB cycle is mandatory between commands).
- Read data latency through the arbiter: `m_readdatavalid` cycle + 1.
- Reset mid-operation clears all state; outstanding reads are discarded.

## Configuration
- `SDRAM_ARB_RR_EN` defined: round-robin.
  - On a simultaneous eligible request, the requester not granted last wins.
  - The pointer updates only on an accepted command.
- Undefined: fixed priority, requester 0 always wins ties. Requester 1 can starve.

## Structure
- Package `sdram_arb_pkg`:
  - state enum {ARB, BUSY}
  - requester ID type (1 bit)
  - `NUM_REQ=2`
- Sub-module `sdram_arb_tag_fifo`:
  - synchronous FIFO, width 1, depth `MAX_PEND`
  - `push`/`pop`/`full`/`empty`, async active-low reset

## Test plan
- Single requester:
  - s0 writes 0xBEEF to address 0x10 with `m_waitrequest` held 3 cycles.
  - Expect `m_write` one cycle after the request; `s0_waitrequest` low exactly on the accept cycle; s1 untouched.
- Read routing:
  - s0 reads 0x20, then s1 reads 0x30; SDRAM returns 0x1111, then 0x2222, 4 cycles later.
  - Expect `s0_readdatavalid`/0x1111, then `s1_readdatavalid`/0x2222, each one cycle after `m_readdatavalid`.
- Simultaneous requests, 4 rounds, with `SDRAM_ARB_RR_EN` defined:
  - Expect the grant order s0, s1, s0, s1.
  - Without the macro: expect s0 on every tie.
- FIFO full:
  - s1 issues 4 reads with no data return; a 5th read stays waiting.
  - An s0 write is still granted.
  - One `m_readdatavalid` beat lets the 5th read issue.
- Spurious data:
  - `m_readdatavalid` with an empty FIFO.
  - Expect `err=1`, no `sN_readdatavalid`; `err` persists until `reset_n` is pulsed.
- Reset mid-operation:
  - Assert `reset_n=0` in BUSY with 2 reads outstanding.
  - Expect all outputs at reset values immediately (asynchronously); after release, late `m_readdatavalid` beats set `err`.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-requester SDRAM arbiter: FSM states, requester ID
// and requester count.
package sdram_arb_pkg;

  localparam int NUM_REQ = 2;

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic [0:0] {
    ARB  = ST_ARB,
    BUSY = ST_BUSY
  } arb_state_t;

  typedef logic [0:0] req_id_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO remembering which requester issued each outstanding pipelined read,
// so returning read beats are routed back in issue order.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  req_id_t push_tag,
  input  logic    pop,
  output req_id_t head_tag,
  output logic    full,
  output logic    empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_id_t        mem [DEPTH];
  logic  [AW:0]   wr_ptr;
  logic  [AW:0]   rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_tag = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_tag;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester Avalon-MM arbiter in front of the SDRAM controller port.
// Define SDRAM_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 4,
  parameter int BE_W     = DATA_W / 8
)(
  input  logic              clk_50,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] s0_address,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  input  logic [BE_W-1:0]   s0_byteenable,
  output logic              s0_waitrequest,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_readdatavalid,

  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  input  logic [BE_W-1:0]   s1_byteenable,
  output logic              s1_waitrequest,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,

  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic [BE_W-1:0]   m_byteenable,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,

  output logic              err
);

  arb_state_t        state;
  req_id_t           grant;
  req_id_t           winner;
  req_id_t           head_tag;
  logic              fifo_full;
  logic              fifo_empty;
  logic              elig0;
  logic              elig1;
  logic              busy;
  logic              accept;
  logic              push;
  logic              sel_read;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_writedata;
  logic [BE_W-1:0]   sel_byteenable;
  logic              rdv_q;
  req_id_t           rtag_q;
  logic [DATA_W-1:0] rdata_q;

  // A read may only win while the tag FIFO can still record its owner.
  assign elig0 = s0_write || (s0_read && !fifo_full);
  assign elig1 = s1_write || (s1_read && !fifo_full);

`ifdef SDRAM_ARB_RR_EN
  req_id_t rr_ptr;

  always_comb begin
    winner = 1'b0;
    if (elig0 && elig1) begin
      winner = rr_ptr;
    end else if (elig1) begin
      winner = 1'b1;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= ~grant;
    end
  end
`else
  assign winner = elig0 ? 1'b0 : 1'b1;
`endif

  assign busy           = (state == BUSY);
  assign sel_read       = grant[0] ? s1_read       : s0_read;
  assign sel_write      = grant[0] ? s1_write      : s0_write;
  assign sel_address    = grant[0] ? s1_address    : s0_address;
  assign sel_writedata  = grant[0] ? s1_writedata  : s0_writedata;
  assign sel_byteenable = grant[0] ? s1_byteenable : s0_byteenable;

  assign m_read       = busy && sel_read;
  assign m_write      = busy && sel_write;
  assign m_address    = busy ? sel_address    : '0;
  assign m_writedata  = busy ? sel_writedata  : '0;
  assign m_byteenable = busy ? sel_byteenable : '0;

  assign accept = busy && (sel_read || sel_write) && !m_waitrequest;
  assign push   = accept && sel_read;

  assign s0_waitrequest = !(busy && (grant == 1'b0) && !m_waitrequest);
  assign s1_waitrequest = !(busy && (grant == 1'b1) && !m_waitrequest);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB;
      grant <= '0;
    end else begin
      case (state)
        ARB: begin
          if (elig0 || elig1) begin
            grant <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (accept || !(sel_read || sel_write)) begin
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  sdram_arb_tag_fifo #(
    .DEPTH    (MAX_PEND)
  ) u_tag_fifo (
    .clk      (clk_50),
    .rst_n    (reset_n),
    .push     (push),
    .push_tag (grant),
    .pop      (m_readdatavalid),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A beat arriving with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      rdv_q   <= 1'b0;
      rtag_q  <= '0;
      rdata_q <= '0;
      err     <= 1'b0;
    end else begin
      rdv_q <= m_readdatavalid && !fifo_empty;
      if (m_readdatavalid && !fifo_empty) begin
        rtag_q  <= head_tag;
        rdata_q <= m_readdata;
      end
      if (m_readdatavalid && fifo_empty) begin
        err <= 1'b1;
      end
    end
  end

  assign s0_readdatavalid = rdv_q && (rtag_q == 1'b0);
  assign s1_readdatavalid = rdv_q && (rtag_q == 1'b1);
  assign s0_readdata      = rdata_q;
  assign s1_readdata      = rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed-plus-random bench for sdram_arbiter, checked against a queue-based
// model of outstanding read owners and the tie-break rule.
module tb_sdram_arbiter;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 16;
  localparam int MAX_PEND = 4;
  localparam int BE_W     = DATA_W / 8;

  logic              clk_50;
  logic              reset_n;
  logic [ADDR_W-1:0] s0_address, s1_address;
  logic              s0_read, s0_write, s1_read, s1_write;
  logic [DATA_W-1:0] s0_writedata, s1_writedata;
  logic [BE_W-1:0]   s0_byteenable, s1_byteenable;
  logic              s0_waitrequest, s1_waitrequest;
  logic [DATA_W-1:0] s0_readdata, s1_readdata;
  logic              s0_readdatavalid, s1_readdatavalid;
  logic [ADDR_W-1:0] m_address;
  logic              m_read, m_write;
  logic [DATA_W-1:0] m_writedata;
  logic [BE_W-1:0]   m_byteenable;
  logic              m_waitrequest;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic              err;

  int errors = 0;
  int checks = 0;

  int exp_tags[$];
  bit model_ptr;
  bit model_err;

  sdram_arbiter #(
    .ADDR_W           (ADDR_W),
    .DATA_W           (DATA_W),
    .MAX_PEND         (MAX_PEND),
    .BE_W             (BE_W)
  ) dut (
    .clk_50           (clk_50),
    .reset_n          (reset_n),
    .s0_address       (s0_address),
    .s0_read          (s0_read),
    .s0_write         (s0_write),
    .s0_writedata     (s0_writedata),
    .s0_byteenable    (s0_byteenable),
    .s0_waitrequest   (s0_waitrequest),
    .s0_readdata      (s0_readdata),
    .s0_readdatavalid (s0_readdatavalid),
    .s1_address       (s1_address),
    .s1_read          (s1_read),
    .s1_write         (s1_write),
    .s1_writedata     (s1_writedata),
    .s1_byteenable    (s1_byteenable),
    .s1_waitrequest   (s1_waitrequest),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .m_address        (m_address),
    .m_read           (m_read),
    .m_write          (m_write),
    .m_writedata      (m_writedata),
    .m_byteenable     (m_byteenable),
    .m_waitrequest    (m_waitrequest),
    .m_readdata       (m_readdata),
    .m_readdatavalid  (m_readdatavalid),
    .err              (err)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_50);
  endtask

  task automatic applyStimulus(input int id, input logic rd, input logic wr,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                               input logic [BE_W-1:0] be);
    if (id == 0) begin
      s0_read = rd; s0_write = wr; s0_address = addr; s0_writedata = data; s0_byteenable = be;
    end else begin
      s1_read = rd; s1_write = wr; s1_address = addr; s1_writedata = data; s1_byteenable = be;
    end
  endtask

  task automatic modelReset();
    exp_tags.delete();
    model_ptr = 1'b0;
    model_err = 1'b0;
  endtask

  task automatic checkReset(input string pfx);
    checkOutput({pfx, "_m_read"},       32'(m_read),           0);
    checkOutput({pfx, "_m_write"},      32'(m_write),          0);
    checkOutput({pfx, "_m_address"},    32'(m_address),        0);
    checkOutput({pfx, "_m_writedata"},  32'(m_writedata),      0);
    checkOutput({pfx, "_m_byteenable"}, 32'(m_byteenable),     0);
    checkOutput({pfx, "_s0_wait"},      32'(s0_waitrequest),   1);
    checkOutput({pfx, "_s1_wait"},      32'(s1_waitrequest),   1);
    checkOutput({pfx, "_s0_rdv"},       32'(s0_readdatavalid), 0);
    checkOutput({pfx, "_s1_rdv"},       32'(s1_readdatavalid), 0);
    checkOutput({pfx, "_s0_rdata"},     32'(s0_readdata),      0);
    checkOutput({pfx, "_s1_rdata"},     32'(s1_readdata),      0);
    checkOutput({pfx, "_err"},          32'(err),              0);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 0, '0, '0, '0);
    m_waitrequest = 1'b1; m_readdatavalid = 1'b0; m_readdata = '0;
    modelReset();
    tick();
    tick();
    checkReset("reset");
    reset_n = 1'b1;
    tick();
  endtask

  // One complete command from requester id; m_waitrequest stays high for waitc cycles.
  task automatic issue(input int id, input bit is_read, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data, input int waitc);
    logic [BE_W-1:0] be;
    be = BE_W'($urandom_range(1, 3));
    applyStimulus(id, is_read, !is_read, addr, data, be);
    tick();
    checkOutput($sformatf("cmd%0d_m_read", id),    32'(m_read),       32'(is_read));
    checkOutput($sformatf("cmd%0d_m_write", id),   32'(m_write),      32'(!is_read));
    checkOutput($sformatf("cmd%0d_m_address", id), 32'(m_address),    32'(addr));
    checkOutput($sformatf("cmd%0d_m_be", id),      32'(m_byteenable), 32'(be));
    if (!is_read) begin
      checkOutput($sformatf("cmd%0d_m_wdata", id), 32'(m_writedata), 32'(data));
    end
    for (int w = 0; w < waitc; w++) begin
      checkOutput($sformatf("cmd%0d_held_self", id), 32'(id == 0 ? s0_waitrequest : s1_waitrequest), 1);
      checkOutput($sformatf("cmd%0d_held_other", id), 32'(id == 0 ? s1_waitrequest : s0_waitrequest), 1);
      tick();
    end
    m_waitrequest = 1'b0;
    #1;
    checkOutput($sformatf("cmd%0d_accept_self", id), 32'(id == 0 ? s0_waitrequest : s1_waitrequest), 0);
    checkOutput($sformatf("cmd%0d_accept_other", id), 32'(id == 0 ? s1_waitrequest : s0_waitrequest), 1);
    tick();
    if (is_read) exp_tags.push_back(id);
    model_ptr = (id == 0);
    applyStimulus(id, 0, 0, addr, data, be);
    m_waitrequest = 1'b1;
    #1;
    checkOutput($sformatf("cmd%0d_idle_after", id), 32'(m_read | m_write), 0);
  endtask

  // One SDRAM read beat; the owning requester sees it exactly one cycle later.
  task automatic returnBeat(input logic [DATA_W-1:0] d);
    int t;
    m_readdatavalid = 1'b1;
    m_readdata      = d;
    #1;
    checkOutput("rdv_same_cycle", 32'(s0_readdatavalid | s1_readdatavalid), 0);
    tick();
    m_readdatavalid = 1'b0;
    m_readdata      = DATA_W'($urandom);
    if (exp_tags.size() == 0) begin
      model_err = 1'b1;
      checkOutput("spurious_s0_rdv", 32'(s0_readdatavalid), 0);
      checkOutput("spurious_s1_rdv", 32'(s1_readdatavalid), 0);
    end else begin
      t = exp_tags.pop_front();
      checkOutput("beat_s0_rdv", 32'(s0_readdatavalid), 32'(t == 0));
      checkOutput("beat_s1_rdv", 32'(s1_readdatavalid), 32'(t == 1));
      checkOutput("beat_rdata", 32'(t == 0 ? s0_readdata : s1_readdata), 32'(d));
    end
    checkOutput("beat_err", 32'(err), 32'(model_err));
    tick();
    checkOutput("rdv_one_pulse", 32'(s0_readdatavalid | s1_readdatavalid), 0);
  endtask

  initial begin
    int              exp_id;
    bit              found;
    logic [ADDR_W-1:0] a5;
    logic [ADDR_W-1:0] aw;

    reset_n = 1'b0;
    doReset();

    // Single requester write held off by the SDRAM for three cycles.
    issue(0, 0, 25'h10, 16'hBEEF, 3);
    checkOutput("single_s1_rdv", 32'(s1_readdatavalid), 0);

    // Read routing: s0 then s1, data returns in order a few cycles later.
    issue(0, 1, 25'h20, DATA_W'($urandom), $urandom_range(1, 3));
    issue(1, 1, 25'h30, DATA_W'($urandom), $urandom_range(1, 3));
    repeat (3) tick();
    returnBeat(16'h1111);
    returnBeat(16'h2222);

    // Random mix of commands and returns.
    for (int i = 0; i < 10; i++) begin
      int  id;
      bit  rd;
      id = int'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (rd && exp_tags.size() >= MAX_PEND) rd = 1'b0;
      issue(id, rd, ADDR_W'($urandom), DATA_W'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0 && exp_tags.size() > 0) returnBeat(DATA_W'($urandom));
    end
    while (exp_tags.size() > 0) returnBeat(DATA_W'($urandom));

    // Simultaneous writes for four rounds.
    doReset();
    applyStimulus(0, 0, 1, 25'h100, 16'hA0A0, 2'b11);
    applyStimulus(1, 0, 1, 25'h200, 16'hB1B1, 2'b11);
    m_waitrequest = 1'b0;
    for (int r = 0; r < 4; r++) begin
      tick();
`ifdef SDRAM_ARB_RR_EN
      exp_id = int'(model_ptr);
`else
      exp_id = 0;
`endif
      checkOutput($sformatf("tie%0d_addr", r), 32'(m_address), exp_id == 1 ? 32'h200 : 32'h100);
      checkOutput($sformatf("tie%0d_wait_win", r), 32'(exp_id == 0 ? s0_waitrequest : s1_waitrequest), 0);
      checkOutput($sformatf("tie%0d_wait_lose", r), 32'(exp_id == 0 ? s1_waitrequest : s0_waitrequest), 1);
      model_ptr = (exp_id == 0);
      tick();
    end
    applyStimulus(0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 0, '0, '0, '0);
    m_waitrequest = 1'b1;
    tick();

    // Tag FIFO full: a fifth read waits, a write still passes.
    for (int i = 0; i < MAX_PEND; i++) begin
      issue(1, 1, ADDR_W'($urandom), DATA_W'($urandom), $urandom_range(0, 2));
    end
    a5 = ADDR_W'($urandom);
    applyStimulus(1, 1, 0, a5, '0, 2'b11);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("full_blocked%0d", k), 32'(m_read), 0);
      checkOutput($sformatf("full_wait%0d", k), 32'(s1_waitrequest), 1);
    end
    aw = ADDR_W'($urandom);
    applyStimulus(0, 0, 1, aw, 16'h5A5A, 2'b01);
    tick();
    checkOutput("full_write_granted", 32'(m_write), 1);
    checkOutput("full_write_addr", 32'(m_address), 32'(aw));
    m_waitrequest = 1'b0;
    #1;
    checkOutput("full_write_accept", 32'(s0_waitrequest), 0);
    tick();
    model_ptr = 1'b1;
    m_waitrequest = 1'b1;
    applyStimulus(0, 0, 0, '0, '0, '0);
    returnBeat(DATA_W'($urandom));
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (m_read) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("full_unblock", 32'(found), 1);
    checkOutput("full_unblock_addr", 32'(m_address), 32'(a5));
    m_waitrequest = 1'b0;
    tick();
    exp_tags.push_back(1);
    model_ptr = 1'b0;
    m_waitrequest = 1'b1;
    applyStimulus(1, 0, 0, '0, '0, '0);
    while (exp_tags.size() > 0) returnBeat(DATA_W'($urandom));

    // Spurious beat sets a sticky error.
    returnBeat(DATA_W'($urandom));
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("err_sticky%0d", k), 32'(err), 1);
    end

    // Reset while BUSY with two reads outstanding.
    issue(0, 1, ADDR_W'($urandom), '0, 1);
    issue(1, 1, ADDR_W'($urandom), '0, 1);
    applyStimulus(0, 0, 1, ADDR_W'($urandom), DATA_W'($urandom), 2'b11);
    tick();
    checkOutput("midrst_busy", 32'(m_write), 1);
    reset_n = 1'b0;
    #1;
    checkReset("midrst");
    modelReset();
    applyStimulus(0, 0, 0, '0, '0, '0);
    tick();
    reset_n = 1'b1;
    tick();
    returnBeat(DATA_W'($urandom));
    returnBeat(DATA_W'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
